// File: rtl/pixel_buf_pkg.sv
// Shared definitions for the pixel buffer write path.
//   - FSM state encodings for pixel_writer (3-bit, two codes unused)
//   - SRAM controller strobe/direction polarities
//   - JPEG marker bytes and the pad byte used for odd-length frames
package pixel_buf_pkg;

    typedef enum logic [2:0] {
        ST_LO    = 3'd0,
        ST_HI    = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FULL  = 3'd5
    } wr_state_t;

    localparam logic SRAM_RW_READ      = 1'b1;
    localparam logic SRAM_RW_WRITE     = 1'b0;
    localparam logic SRAM_START_ACTIVE = 1'b0;

    localparam logic [7:0] JPEG_MARK = 8'hFF;
    localparam logic [7:0] JPEG_EOI  = 8'hD9;
    localparam logic [7:0] PAD_BYTE  = 8'h00;

    // True when the byte completes an FF D9 end-of-image marker.
    function automatic logic is_eoi(input logic prev_ff, input logic [7:0] b);
        return prev_ff && (b == JPEG_EOI);
    endfunction

endpackage

// File: rtl/jpeg_eoi_detect.sv
// Tracks whether the previous accepted byte was 0xFF and flags an accepted
// 0xD9 that follows it (JPEG end-of-image marker).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - frame restart, forgets the previous byte
//   byte_in     - byte being accepted
//   strobe      - byte_in is accepted this cycle
//   eoi         - combinational: this accepted byte completes FF D9
module jpeg_eoi_detect
    import pixel_buf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] byte_in,
    input  logic       strobe,
    output logic       eoi
);

    logic prev_ff;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prev_ff <= 1'b0;
        end else if (strobe) begin
            prev_ff <= (byte_in == JPEG_MARK);
        end
    end

    assign eoi = strobe && is_eoi(prev_ff, byte_in);

endmodule

// File: rtl/pixel_writer.sv
// Packs a JPEG byte stream into 16-bit words (first byte low, second high)
// and writes them sequentially to SRAM through the shared controller.
// Raises frame_done once the word holding the FF D9 marker is committed.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   frame_clear             - pulse: end/abandon frame, rearm at START_ADDR
//   byte_in, byte_valid     - incoming byte and its valid
//   byte_ready              - byte accepted when byte_valid && byte_ready
//   sram_ready              - controller has completed the write
//   sram_addr, sram_wdata   - word address and data of the write
//   sram_rw                 - always write (0)
//   sram_start              - active-low one-cycle start strobe
//   frame_done              - EOI committed, held until clear/reset
//   overflow                - sticky, a byte arrived after the buffer filled
//   byte_count              - only with PIXEL_WRITER_BYTE_COUNT_EN defined:
//                             bytes committed this frame (pad excluded)
//
// state | meaning
// LO    | waiting for the low byte of a word
// HI    | waiting for the high byte of a word
// START | sram_start asserted for one cycle
// WAIT  | write in flight, waiting for sram_ready
// DONE  | EOI committed, input ignored
// FULL  | MAX_ADDR written, input accepted and discarded
module pixel_writer
    import pixel_buf_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] MAX_ADDR   = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_clear,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              sram_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    output logic              sram_rw,
    output logic              sram_start,
    output logic              frame_done,
    output logic              overflow
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
    ,
    output logic [ADDR_W:0]   byte_count
`endif
);

    wr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              eoi_pend_q;
    logic              clr_pend_q;
    logic              pad_q;
    logic              take;
    logic              eoi;
    logic              do_clear;
    logic              word_done;
    logic              bad_state;

    // A byte is stored only in LO/HI; a simultaneous frame_clear drops it.
    assign take = byte_valid && !frame_clear &&
                  ((state_q == ST_LO) || (state_q == ST_HI));

    jpeg_eoi_detect u_eoi (
        .clk     (clk),
        .reset   (reset),
        .clear   (do_clear || bad_state),
        .byte_in (byte_in),
        .strobe  (take),
        .eoi     (eoi)
    );

    assign sram_rw = SRAM_RW_WRITE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        sram_start = ~SRAM_START_ACTIVE;
        frame_done = 1'b0;
        do_clear   = 1'b0;
        word_done  = 1'b0;
        bad_state  = 1'b0;
        case (state_q)
            ST_LO: begin
                byte_ready = 1'b1;
                if (frame_clear) begin
                    do_clear = 1'b1;
                end else if (byte_valid) begin
                    // EOI as a low byte closes the word with a pad byte.
                    state_d = eoi ? ST_START : ST_HI;
                end
            end
            ST_HI: begin
                byte_ready = 1'b1;
                if (frame_clear) begin
                    do_clear = 1'b1;
                    state_d  = ST_LO;
                end else if (byte_valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                sram_start = SRAM_START_ACTIVE;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (sram_ready) begin
                    word_done = 1'b1;
                    // A clear seen during the write only lands once it completes.
                    if (clr_pend_q || frame_clear) begin
                        do_clear = 1'b1;
                        state_d  = ST_LO;
                    end else if (eoi_pend_q) begin
                        state_d = ST_DONE;
                    end else if (ptr_q == MAX_ADDR) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                if (frame_clear) begin
                    do_clear = 1'b1;
                    state_d  = ST_LO;
                end
            end
            ST_FULL: begin
                byte_ready = 1'b1;
                if (frame_clear) begin
                    do_clear = 1'b1;
                    state_d  = ST_LO;
                end
            end
            default: begin
                bad_state = 1'b1;
                state_d   = ST_LO;
            end
        endcase
    end

`ifdef PIXEL_WRITER_BYTE_COUNT_EN
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_TWO = (ADDR_W+1)'(2);
    logic [ADDR_W:0] byte_cnt_q;
    assign byte_count = byte_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset || bad_state) begin
            ptr_q      <= START_ADDR;
            sram_addr  <= START_ADDR;
            sram_wdata <= '0;
            overflow   <= 1'b0;
            eoi_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            pad_q      <= 1'b0;
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
            byte_cnt_q <= '0;
`endif
        end else if (do_clear) begin
            ptr_q      <= START_ADDR;
            overflow   <= 1'b0;
            eoi_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            pad_q      <= 1'b0;
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
            byte_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_LO: begin
                    if (take) begin
                        sram_wdata[7:0] <= byte_in;
                        pad_q           <= eoi;
                        if (eoi) begin
                            sram_wdata[15:8] <= PAD_BYTE;
                            eoi_pend_q       <= 1'b1;
                            sram_addr        <= ptr_q;
                        end
                    end
                end
                ST_HI: begin
                    if (take) begin
                        sram_wdata[15:8] <= byte_in;
                        sram_addr        <= ptr_q;
                        if (eoi) begin
                            eoi_pend_q <= 1'b1;
                        end
                    end
                end
                ST_START, ST_WAIT: begin
                    if (frame_clear) begin
                        clr_pend_q <= 1'b1;
                    end
                    if (word_done) begin
                        ptr_q <= ptr_q + ADDR_W'(1);
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
                        byte_cnt_q <= byte_cnt_q + (pad_q ? CNT_ONE : CNT_TWO);
`endif
                    end
                end
                ST_FULL: begin
                    if (byte_valid) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        frame_clear;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        byte_ready, sram_ready, sram_rw, sram_start, frame_done, overflow;
    logic [15:0] sram_addr, sram_wdata;
    logic        byte_ready2, sram_ready2, sram_rw2, sram_start2, frame_done2, overflow2;
    logic [15:0] sram_addr2, sram_wdata2;
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
    logic [16:0] byte_count, byte_count2;
`endif

    always #5 clk = ~clk;

    pixel_writer dut (
        .clk(clk), .reset(reset), .frame_clear(frame_clear),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .sram_ready(sram_ready), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rw(sram_rw), .sram_start(sram_start), .frame_done(frame_done),
        .overflow(overflow)
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
        , .byte_count(byte_count)
`endif
    );

    pixel_writer #(.MAX_ADDR(16'd1)) dut_full (
        .clk(clk), .reset(reset2), .frame_clear(frame_clear),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready2),
        .sram_ready(sram_ready2), .sram_addr(sram_addr2), .sram_wdata(sram_wdata2),
        .sram_rw(sram_rw2), .sram_start(sram_start2), .frame_done(frame_done2),
        .overflow(overflow2)
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
        , .byte_count(byte_count2)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // SRAM controller models: log each write, answer after lat cycles.
    logic [31:0] wq1[$];
    logic [31:0] wq2[$];
    int lat1 = 3;
    logic chk_br = 1'b0;
    int br_viol = 0;

    initial begin
        sram_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (sram_start === 1'b0) begin
                wq1.push_back({sram_addr, sram_wdata});
                for (int k = 0; k <= lat1; k++) begin
                    if (chk_br && byte_ready !== 1'b0) br_viol++;
                    if (k == lat1) sram_ready = 1'b1;
                    @(negedge clk);
                end
                sram_ready = 1'b0;
            end
        end
    end

    initial begin
        sram_ready2 = 1'b0;
        forever begin
            @(negedge clk);
            if (sram_start2 === 1'b0) begin
                wq2.push_back({sram_addr2, sram_wdata2});
                repeat (2) @(negedge clk);
                sram_ready2 = 1'b1;
                @(negedge clk);
                sram_ready2 = 1'b0;
            end
        end
    end

    // Start strobe must never stay low for two consecutive cycles.
    int start_viol = 0;
    int start2_cnt = 0;
    initial begin
        logic prev_low = 1'b0;
        forever begin
            @(negedge clk);
            if (sram_start === 1'b0) begin
                if (prev_low) start_viol++;
                prev_low = 1'b1;
            end else begin
                prev_low = 1'b0;
            end
            if (sram_start2 === 1'b0) start2_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // sel 0 = dut, 1 = dut_full. Called at a negedge.
    task automatic send(input int sel, input logic [7:0] b);
        logic rdy;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rdy = (sel == 0) ? byte_ready : byte_ready2;
            if (rdy) begin
                @(negedge clk);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_raw(input logic [7:0] b, input int n);
        byte_in    = b;
        byte_valid = 1'b1;
        repeat (n) @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        frame_clear = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 200 && wq1.size() < n; i++) @(negedge clk);
        chk("word_count", wq1.size(), n);
        repeat (lat1 + 3) @(negedge clk);
    endtask

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][7:0]  b;
        logic [1:0]       nw;
        logic [1:0][15:0] w;
        logic             done;
        logic [3:0]       bc;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] n, input logic [31:0] b,
                                input logic [1:0] nw, input logic [31:0] w,
                                input logic done, input logic [3:0] bc);
        vec_t v;
        v.n = n; v.b = b; v.nw = nw; v.w = w; v.done = done; v.bc = bc;
        return v;
    endfunction

    localparam int NV = 6;
    vec_t vec[NV];

    initial begin
        // bytes listed high-index first; b[0] is sent first, w[0] written first
        vec[0] = mk(3'd4, 32'h44332211, 2'd2, 32'h4433_2211, 1'b0, 4'd4);
        vec[1] = mk(3'd3, 32'h00D9FF12, 2'd2, 32'h00D9_FF12, 1'b1, 4'd3);
        vec[2] = mk(3'd2, 32'h0000D9FF, 2'd1, 32'h0000_D9FF, 1'b1, 4'd2);
        vec[3] = mk(3'd4, 32'h5AD900FF, 2'd2, 32'h5AD9_00FF, 1'b0, 4'd4);
        vec[4] = mk(3'd3, 32'h00D9FFAA, 2'd2, 32'h00D9_FFAA, 1'b1, 4'd3);
        vec[5] = mk(3'd3, 32'h00D9FFFF, 2'd2, 32'h00D9_FFFF, 1'b1, 4'd3);

        reset = 1'b1; reset2 = 1'b1;
        frame_clear = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_sram_start", sram_start, 1'b1);
        chk("rst_sram_rw",    sram_rw,    1'b0);
        chk("rst_byte_ready", byte_ready, 1'b1);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_overflow",   overflow,   1'b0);
        chk("rst_sram_addr",  sram_addr,  16'h0000);
        chk("rst_sram_wdata", sram_wdata, 16'h0000);

        chk_br = 1'b1;
        for (int v = 0; v < NV; v++) begin
            pulse_clear();
            wq1.delete();
            for (int i = 0; i < int'(vec[v].n); i++) send(0, vec[v].b[i]);
            wait_words(int'(vec[v].nw));
            for (int i = 0; i < int'(vec[v].nw); i++) begin
                logic [15:0] a;
                a = 16'(i);
                chk($sformatf("v%0d_word%0d", v, i), (i < wq1.size()) ? wq1[i] : 32'hDEAD_DEAD,
                    {a, vec[v].w[i]});
            end
            chk($sformatf("v%0d_frame_done", v), frame_done, vec[v].done);
`ifdef PIXEL_WRITER_BYTE_COUNT_EN
            chk($sformatf("v%0d_byte_count", v), byte_count, {13'd0, vec[v].bc});
`endif
            if (vec[v].done) begin
                chk($sformatf("v%0d_done_ready", v), byte_ready, 1'b0);
                push_raw(8'h11, 3);
                repeat (lat1 + 3) @(negedge clk);
                chk($sformatf("v%0d_ignored", v), wq1.size(), int'(vec[v].nw));
                chk($sformatf("v%0d_done_hold", v), frame_done, 1'b1);
            end
        end
        chk_br = 1'b0;
        chk("busy_byte_ready_low", br_viol, 0);
        chk("start_one_cycle", start_viol, 0);

        pulse_clear();
        chk("clear_frame_done", frame_done, 1'b0);

        // frame_clear wins over a same-cycle byte, partial byte discarded
        wq1.delete();
        send(0, 8'h77);
        byte_in = 8'h88; byte_valid = 1'b1; frame_clear = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; frame_clear = 1'b0;
        send(0, 8'h99);
        send(0, 8'hAA);
        wait_words(1);
        chk("clr_byte_word", wq1.size() > 0 ? wq1[0] : 32'hDEAD_DEAD, 32'h0000_AA99);

        // frame_clear during WAIT: write completes, then pointer rearms
        lat1 = 6;
        pulse_clear();
        wq1.delete();
        send(0, 8'h11);
        send(0, 8'h22);
        @(negedge clk);
        frame_clear = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0;
        chk("clr_wait_busy", byte_ready, 1'b0);
        wait_words(1);
        chk("clr_wait_ready", byte_ready, 1'b1);
        send(0, 8'h33);
        send(0, 8'h44);
        wait_words(2);
        chk("clr_wait_w0", wq1.size() > 0 ? wq1[0] : 32'hDEAD_DEAD, 32'h0000_2211);
        chk("clr_wait_w1", wq1.size() > 1 ? wq1[1] : 32'hDEAD_DEAD, 32'h0000_4433);
        lat1 = 3;

        // reset mid-frame, while the third word is in flight
        pulse_clear();
        wq1.delete();
        for (int i = 1; i <= 6; i++) send(0, 8'(8'h11 * i));
        @(negedge clk);
        chk("pre_rst_addr", sram_addr, 16'h0002);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_sram_start", sram_start, 1'b1);
        chk("mid_rst_byte_ready", byte_ready, 1'b1);
        chk("mid_rst_sram_addr",  sram_addr,  16'h0000);
        chk("mid_rst_sram_wdata", sram_wdata, 16'h0000);
        chk("mid_rst_frame_done", frame_done, 1'b0);
        repeat (8) @(negedge clk);
        wq1.delete();
        send(0, 8'hAB);
        send(0, 8'hCD);
        wait_words(1);
        chk("post_rst_word", wq1.size() > 0 ? wq1[0] : 32'hDEAD_DEAD, 32'h0000_CDAB);

        // buffer full with MAX_ADDR = 1
        reset2 = 1'b0;
        @(negedge clk);
        start2_cnt = 0;
        for (int i = 1; i <= 4; i++) send(1, 8'(i));
        repeat (8) @(negedge clk);
        chk("full_words", wq2.size(), 2);
        chk("full_w0", wq2.size() > 0 ? wq2[0] : 32'hDEAD_DEAD, 32'h0000_0201);
        chk("full_w1", wq2.size() > 1 ? wq2[1] : 32'hDEAD_DEAD, 32'h0001_0403);
        chk("full_ovf_before", overflow2, 1'b0);
        chk("full_ready", byte_ready2, 1'b1);
        send(1, 8'h05);
        chk("full_ovf_after5", overflow2, 1'b1);
        send(1, 8'h06);
        repeat (6) @(negedge clk);
        chk("full_no_more_words", wq2.size(), 2);
        chk("full_start_count", start2_cnt, 2);
        chk("full_ovf_sticky", overflow2, 1'b1);
        chk("full_no_done", frame_done2, 1'b0);
        pulse_clear();
        chk("full_clear_ovf", overflow2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Write-side counterpart of the buffer's pixel read path.
- Accepts a JPEG byte stream from the camera/SPI capture side and packs byte pairs into 16-bit words, first byte in [7:0] and second in [15:8].
- Writes each word sequentially to SRAM through the shared single-port SRAM controller and raises frame_done after the FF D9 end-of-image marker has been committed.
- Held idle by the buffer controller via frame_clear when the buffer is owned by the reader.

Parameters:
ADDR_W, 16, SRAM word address width
START_ADDR, 0, first word address of a frame
MAX_ADDR, 16'hFFFF, last writable word address

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_clear  in  1  one-cycle pulse: abandon/finish frame, rearm at START_ADDR
byte_in  in  8  incoming pixel/JPEG byte
byte_valid  in  1  byte_in valid this cycle
byte_ready  out  1  writer can accept byte this cycle
sram_ready  in  1  SRAM controller done (1 = done)
sram_addr  out  ADDR_W  word write address
sram_wdata  out  16  word write data
sram_rw  out  1  0 = write; held 0 permanently
sram_start  out  1  active-low one-cycle start strobe
frame_done  out  1  EOI written; held until frame_clear/reset
overflow  out  1  a byte was dropped because the buffer was full; sticky

Behaviour:
- Only clk is used; reset is synchronous and active-high and wins over every other input.
- Reset values: state=LO, sram_addr=START_ADDR, sram_wdata=0, sram_start=1, sram_rw=0, frame_done=0, overflow=0, byte_ready=1, internal word pointer=START_ADDR, prev_ff=0.
- Handshake: a byte is transferred on a cycle with byte_valid && byte_ready. byte_ready=1 only in LO and HI.
- LO: on transfer, latch byte into sram_wdata[7:0], go to HI.
- HI: on transfer, latch byte into sram_wdata[15:8], go to START.
- START (1 cycle): sram_addr=pointer, sram_start=0, go to WAIT.
- WAIT: sram_start=1.
  - On sram_ready=1: pointer+1; go to DONE if eoi_pending, else LO.
  - sram_ready is not sampled in the START cycle.
- DONE: frame_done=1, byte_ready=0; bytes are ignored.
- Word latency: sram_start falls the cycle after the second byte is accepted.
- EOI detection:
  - prev_ff is set on each accepted 0xFF byte and cleared on any other accepted byte.
  - An accepted 0xD9 with prev_ff=1 sets eoi_pending, regardless of word alignment.
- If D9 lands as a low byte (in LO), the writer goes straight to START with sram_wdata[15:8]=8'h00 as pad.
- Full:
  - After the word at MAX_ADDR is written and eoi_pending=0, the state becomes FULL.
  - In FULL, byte_ready=1 and bytes are accepted and discarded. The first discarded byte sets overflow.
  - No wrap-around.
- frame_clear:
  - In LO/HI/DONE/FULL: return to LO, pointer=START_ADDR, clear frame_done, overflow, prev_ff and eoi_pending; any partial byte is discarded.
  - In START/WAIT: recorded. It takes effect once sram_ready completes the in-flight write, so the SRAM transaction is never truncated.
- frame_clear and byte transfer in the same cycle: frame_clear wins and the byte is dropped.
- State encoding is 3 bits: LO, HI, START, WAIT, DONE, FULL. Illegal codes behave as reset.

Optional Feature:
- Macro PIXEL_WRITER_BYTE_COUNT_EN.
- Defined:
  - Adds output byte_count [ADDR_W:0], the number of bytes committed to SRAM in the current frame, including the EOI bytes but excluding the pad byte.
  - Updated when sram_ready completes each word; cleared by reset and frame_clear; frozen in DONE/FULL.
  - Lets the reader stop without scanning for the marker.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package pixel_buf_pkg holds:
  - state encodings;
  - SRAM_RW_READ=1 and SRAM_RW_WRITE=0;
  - SRAM_START_ACTIVE=0;
  - JPEG_MARK=8'hFF, JPEG_EOI=8'hD9;
  - PAD_BYTE=8'h00.
- Sub-module jpeg_eoi_detect (clk, reset, clear, byte, strobe -> eoi) holds the prev_ff tracking. Everything else stays in pixel_writer.

Test Plan:
- Stream 11 22 33 44 with SRAM ready 3 cycles after start -> writes 16'h2211@0 and 16'h4433@1; sram_start low exactly one cycle per word; byte_ready low during START/WAIT.
- Stream 12 FF D9 (EOI odd-aligned) -> writes 16'hFF12@0, then 16'h00D9@1; frame_done=1; further bytes ignored.
- Stream FF D9 (EOI even-aligned) -> writes 16'hD9FF@0; frame_done=1 after sram_ready; FF 00 D9 does not trigger EOI.
- Set MAX_ADDR=1 and send 6 bytes -> words at 0 and 1 only; overflow=1 after 5th byte; sram_start never asserted again.
- frame_clear pulsed during WAIT -> in-flight write completes, then pointer=START_ADDR; reset asserted mid-frame -> next cycle all outputs at reset values and sram_start=1.
- With PIXEL_WRITER_BYTE_COUNT_EN, stream AA FF D9 -> byte_count=3 at frame_done.
